// File: rtl/echo_queue_pkg.sv
// Shared types for the echo message queue: entry kind and the logical entry layout.
package echo_queue_pkg;

  typedef enum logic {
    KIND_SAY  = 1'b0,
    KIND_SAY2 = 1'b1
  } kind_e;

  // Payload sized for the widest supported DATA_W; queue slots keep the same
  // {kind, payload} field order but only store DATA_W payload bits.
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    kind_e                  kind;
    logic [MAX_DATA_W-1:0]  payload;
  } entry_t;

endpackage

// File: rtl/echo_queue_if.sv
// Method/indication bundle of echo_queue; slave is the queue side, master the caller side.
interface echo_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LED_W  = 8
);
  localparam int HALF_W = DATA_W / 2;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic              say__ENA;
  logic [DATA_W-1:0] say_v;
  logic              say__RDY;

  logic              say2__ENA;
  logic [HALF_W-1:0] say2_a;
  logic [HALF_W-1:0] say2_b;
  logic              say2__RDY;

  logic              setLeds__ENA;
  logic [LED_W-1:0]  setLeds_v;
  logic              setLeds__RDY;

  logic              heard__ENA;
  logic [DATA_W-1:0] heard_v;
  logic              heard__RDY;

  logic              heard2__ENA;
  logic [HALF_W-1:0] heard2_a;
  logic [HALF_W-1:0] heard2_b;
  logic              heard2__RDY;

  logic [LED_W-1:0]  leds;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  say__ENA, say_v, say2__ENA, say2_a, say2_b, setLeds__ENA, setLeds_v,
           heard__RDY, heard2__RDY,
    output say__RDY, say2__RDY, setLeds__RDY, heard__ENA, heard_v,
           heard2__ENA, heard2_a, heard2_b, leds, occupancy
  );

  modport master (
    output say__ENA, say_v, say2__ENA, say2_a, say2_b, setLeds__ENA, setLeds_v,
           heard__RDY, heard2__RDY,
    input  say__RDY, say2__RDY, setLeds__RDY, heard__ENA, heard_v,
           heard2__ENA, heard2_a, heard2_b, leds, occupancy
  );

endinterface

// File: rtl/echo_queue_fifo.sv
// Circular queue storage with two ordered write ports, one read port and occupancy.
module echo_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr0_en_i,
  input  logic [WIDTH-1:0]           wr0_data_i,
  input  logic                       wr1_en_i,
  input  logic [WIDTH-1:0]           wr1_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_nxt;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [1:0]       n_wr;

  // wr1 is only ever used together with wr0 and lands one slot after it.
  always_comb begin
    n_wr     = {1'b0, wr0_en_i} + {1'b0, wr1_en_i};
    wptr_nxt = wptr_q + PTR_W'(1);
    wptr_d   = wptr_q + PTR_W'(n_wr);
    rptr_d   = rptr_q + PTR_W'(rd_en_i);
    occ_d    = occ_q + OCC_W'(n_wr) - OCC_W'(rd_en_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr0_en_i) mem_q[wptr_q]   <= wr0_data_i;
    if (wr1_en_i) mem_q[wptr_nxt] <= wr1_data_i;
  end

  assign rd_data_o   = mem_q[rptr_q];
  assign occupancy_o = occ_q;

endmodule

// File: rtl/echo_queue.sv
// Echo queue: say/say2 requests are queued and replayed as heard/heard2 indications; plus an LED register.
module echo_queue
  import echo_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LED_W  = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  echo_queue_if.slave bus
);
  localparam int HALF_W = DATA_W / 2;
  localparam int OCC_W  = $clog2(DEPTH) + 1;
  localparam int SLOT_W = $bits(kind_e) + DATA_W;

  logic [OCC_W-1:0]  occ;
  logic [SLOT_W-1:0] wr0_data, wr1_data, head;
  logic              say_fire, say2_fire, set_fire, wr0_en, wr1_en, pop, has_head;
  kind_e             head_kind;
  logic [LED_W-1:0]  leds_q, leds_d;

  // Readiness depends on registered occupancy only, so a same-cycle pop never frees a slot.
  assign bus.say__RDY     = (occ < OCC_W'(DEPTH));
  assign bus.say2__RDY    = (occ < OCC_W'(DEPTH - 1));
  assign bus.setLeds__RDY = 1'b1;

  assign say_fire  = bus.say__ENA  & bus.say__RDY;
  assign say2_fire = bus.say2__ENA & bus.say2__RDY;
  assign set_fire  = bus.setLeds__ENA & bus.setLeds__RDY;

  always_comb begin
    wr0_en   = say_fire | say2_fire;
    wr1_en   = say_fire & say2_fire;
    wr1_data = {KIND_SAY2, bus.say2_a, bus.say2_b};
    wr0_data = say_fire ? {KIND_SAY, bus.say_v} : wr1_data;
  end

  echo_fifo #(
    .WIDTH (SLOT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .wr0_en_i    (wr0_en),
    .wr0_data_i  (wr0_data),
    .wr1_en_i    (wr1_en),
    .wr1_data_i  (wr1_data),
    .rd_en_i     (pop),
    .rd_data_o   (head),
    .occupancy_o (occ)
  );

  always_comb begin
    has_head        = (occ != '0);
    head_kind       = kind_e'(head[DATA_W]);
    bus.heard__ENA  = has_head && (head_kind == KIND_SAY)  && bus.heard__RDY;
    bus.heard2__ENA = has_head && (head_kind == KIND_SAY2) && bus.heard2__RDY;
    bus.heard_v     = bus.heard__ENA  ? head[DATA_W-1:0]      : '0;
    bus.heard2_a    = bus.heard2__ENA ? head[DATA_W-1:HALF_W] : '0;
    bus.heard2_b    = bus.heard2__ENA ? head[HALF_W-1:0]      : '0;
    pop             = bus.heard__ENA | bus.heard2__ENA;
  end

  always_comb begin
    leds_d = leds_q;
    if (set_fire) leds_d = bus.setLeds_v;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) leds_q <= '0;
    else       leds_q <= leds_d;
  end

  assign bus.leds      = leds_q;
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_echo_queue.sv
// Directed bench for echo_queue: reset, latency, ordering, full/ready corners, wrap and async reset.
module tb_echo_queue;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LED_W  = 8;
  localparam int NCALLS = 3 * DEPTH;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  echo_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LED_W(LED_W)) bus ();

  echo_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LED_W(LED_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.say__ENA     = 1'b0;
    bus.say_v        = '0;
    bus.say2__ENA    = 1'b0;
    bus.say2_a       = '0;
    bus.say2_b       = '0;
    bus.setLeds__ENA = 1'b0;
    bus.setLeds_v    = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference queue: bit 32 = kind (1 = say2), bits 31:0 = payload
  logic [32:0] model[$];
  int          calls;
  logic        hr, h2r, exp_h, exp_h2, accept, is2;
  logic [31:0] ev;
  logic [15:0] ea, eb;

  initial begin
    idle();
    bus.heard__RDY  = 1'b0;
    bus.heard2__RDY = 1'b0;

    // Reset values
    #2;
    check("rst_occ", bus.occupancy, 0);
    check("rst_leds", bus.leds, 0);
    check("rst_say_rdy", bus.say__RDY, 1);
    check("rst_say2_rdy", bus.say2__RDY, 1);
    check("rst_heard_ena", bus.heard__ENA, 0);
    check("rst_heard2_ena", bus.heard2__ENA, 0);
    check("rst_setleds_rdy", bus.setLeds__RDY, 1);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Single say: one cycle latency, no bypass
    bus.heard__RDY  = 1'b1;
    bus.heard2__RDY = 1'b1;
    bus.say__ENA    = 1'b1;
    bus.say_v       = 32'hDEADBEEF;
    #1;
    check("t1_no_bypass", bus.heard__ENA, 0);
    next_cycle();
    idle();
    #1;
    check("t1_heard_ena", bus.heard__ENA, 1);
    check("t1_heard_v", bus.heard_v, 32'hDEADBEEF);
    check("t1_occ1", bus.occupancy, 1);
    next_cycle();
    #1;
    check("t1_occ0", bus.occupancy, 0);
    check("t1_heard_idle", bus.heard__ENA, 0);
    check("t1_heard_v_zero", bus.heard_v, 0);

    // say + say2 same cycle, with an LED write alongside
    bus.say__ENA     = 1'b1;
    bus.say_v        = 32'h1;
    bus.say2__ENA    = 1'b1;
    bus.say2_a       = 16'h1234;
    bus.say2_b       = 16'h5678;
    bus.setLeds__ENA = 1'b1;
    bus.setLeds_v    = 8'hA5;
    next_cycle();
    idle();
    #1;
    check("t2_occ2", bus.occupancy, 2);
    check("t2_leds", bus.leds, 8'hA5);
    check("t2_heard_ena", bus.heard__ENA, 1);
    check("t2_heard_v", bus.heard_v, 1);
    check("t2_heard2_idle", bus.heard2__ENA, 0);
    check("t2_heard2_a_zero", bus.heard2_a, 0);
    next_cycle();
    #1;
    check("t2_occ1", bus.occupancy, 1);
    check("t2_heard2_ena", bus.heard2__ENA, 1);
    check("t2_heard2_a", bus.heard2_a, 16'h1234);
    check("t2_heard2_b", bus.heard2_b, 16'h5678);
    check("t2_heard_idle", bus.heard__ENA, 0);
    next_cycle();
    #1;
    check("t2_occ0", bus.occupancy, 0);

    // Fill to DEPTH with indications stalled
    bus.heard__RDY  = 1'b0;
    bus.heard2__RDY = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("t4_occ_fill", bus.occupancy, i);
      check("t4_say_rdy", bus.say__RDY, 1);
      check("t4_say2_rdy", bus.say2__RDY, (i < DEPTH - 1) ? 1 : 0);
      bus.say__ENA = 1'b1;
      bus.say_v    = 32'h10 + i;
      next_cycle();
    end
    idle();
    #1;
    check("t4_occ_full", bus.occupancy, DEPTH);
    check("t4_say_rdy_full", bus.say__RDY, 0);
    check("t4_say2_rdy_full", bus.say2__RDY, 0);
    check("t4_heard_stalled", bus.heard__ENA, 0);
    bus.say__ENA = 1'b1;
    bus.say_v    = 32'h99;
    next_cycle();
    #1;
    check("t4_fifth_ignored", bus.occupancy, DEPTH);

    // Pop with say retried in the same cycle: pre-pop RDY blocks the push
    bus.heard__RDY = 1'b1;
    bus.say_v      = 32'h77;
    #1;
    check("t5_pop_ena", bus.heard__ENA, 1);
    check("t5_pop_v", bus.heard_v, 32'h10);
    next_cycle();
    idle();
    #1;
    check("t5_occ3", bus.occupancy, DEPTH - 1);
    for (int j = 1; j < DEPTH; j++) begin
      #1;
      check("t5_drain_v", bus.heard_v, 32'h10 + j);
      next_cycle();
    end
    #1;
    check("t5_drained", bus.occupancy, 0);

    // Alternating say/say2 with random indication readiness, against a reference queue
    calls = 0;
    for (int cyc = 0; cyc < 400 && (calls < NCALLS || model.size() > 0); cyc++) begin
      idle();
      hr  = 1'($urandom_range(0, 1));
      h2r = 1'($urandom_range(0, 1));
      bus.heard__RDY  = hr;
      bus.heard2__RDY = h2r;
      is2 = 1'(calls % 2);
      if (calls < NCALLS) begin
        if (!is2) begin
          bus.say__ENA = 1'b1;
          bus.say_v    = 32'hA000_0000 + calls;
        end else begin
          bus.say2__ENA = 1'b1;
          bus.say2_a    = 16'h2000 + 16'(calls);
          bus.say2_b    = 16'h3000 + 16'(calls);
        end
      end
      #1;
      exp_h = 1'b0; exp_h2 = 1'b0; ev = '0; ea = '0; eb = '0;
      if (model.size() > 0) begin
        if (!model[0][32]) begin
          exp_h = hr;
          if (hr) ev = model[0][31:0];
        end else begin
          exp_h2 = h2r;
          if (h2r) begin
            ea = model[0][31:16];
            eb = model[0][15:0];
          end
        end
      end
      check("t6_occ", bus.occupancy, model.size());
      check("t6_say_rdy", bus.say__RDY, (model.size() < DEPTH) ? 1 : 0);
      check("t6_say2_rdy", bus.say2__RDY, (model.size() < DEPTH - 1) ? 1 : 0);
      check("t6_heard_ena", bus.heard__ENA, exp_h);
      check("t6_heard_v", bus.heard_v, ev);
      check("t6_heard2_ena", bus.heard2__ENA, exp_h2);
      check("t6_heard2_a", bus.heard2_a, ea);
      check("t6_heard2_b", bus.heard2_b, eb);
      accept = (calls < NCALLS) && (is2 ? (model.size() < DEPTH - 1) : (model.size() < DEPTH));
      @(posedge CLK);
      if (exp_h || exp_h2) void'(model.pop_front());
      if (accept) begin
        if (!is2) model.push_back({1'b0, 32'hA000_0000 + calls});
        else      model.push_back({1'b1, 16'h2000 + 16'(calls), 16'h3000 + 16'(calls)});
        calls++;
      end
      @(negedge CLK);
    end
    idle();
    #1;
    check("t6_calls_done", calls, NCALLS);
    check("t6_model_empty", model.size(), 0);
    check("t6_occ_end", bus.occupancy, 0);

    // Asynchronous reset with 3 entries queued
    bus.heard__RDY  = 1'b0;
    bus.heard2__RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.say__ENA = 1'b1;
      bus.say_v    = 32'h50 + i;
      next_cycle();
    end
    idle();
    #1;
    check("t7_occ3", bus.occupancy, 3);
    check("t7_leds_held", bus.leds, 8'hA5);
    bus.heard__RDY  = 1'b1;
    bus.heard2__RDY = 1'b1;
    #1;
    check("t7_heard_before_rst", bus.heard__ENA, 1);
    #1;
    nRST = 1'b0;
    #1;
    check("t7_heard_async_drop", bus.heard__ENA, 0);
    check("t7_heard2_async_drop", bus.heard2__ENA, 0);
    check("t7_occ_rst", bus.occupancy, 0);
    check("t7_leds_rst", bus.leds, 0);
    check("t7_say2_rdy_rst", bus.say2__RDY, 1);
    next_cycle();
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t7_post_heard", bus.heard__ENA, 0);
      check("t7_post_heard2", bus.heard2__ENA, 0);
      check("t7_post_occ", bus.occupancy, 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
